int_to_fpu_encoder: RTL and testbench
=====================================

Name: int_to_fpu_encoder

Overview:
- Converts a signed 32-bit fixed-point integer into the team's 32-bit float operand format: [31] sign, [30:21] 10-bit biased exponent, [20:0] 21-bit mantissa with a hidden leading 1.
- Sits on the operand side of the FPU adder: it produces op_A_in/op_B_in words, and the adder consumes them.
- Reports status with the same 4-bit one-hot encoding the adder uses.
- Uses a multi-cycle iterative normaliser, with valid/ready handshakes on both ends.

Parameters:
- FRAC_BITS, default 0: number of fractional bits in the input. Input is Q(32-FRAC_BITS).FRAC_BITS two's complement. Legal range 0..31.
- BIAS, default 511: exponent bias.

Ports:
- clock_100KHz  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  int_in is valid.
- in_ready  out  1  block can accept a value; high only in IDLE.
- int_in  in  32  signed fixed-point input.
- out_valid  out  1  data_out and status_out hold a result.
- out_ready  in  1  downstream accepts the result.
- data_out  out  32  encoded float word.
- status_out  out  4  0000 idle, 0001 EXACT, 0010 OVERFLOW, 0100 UNDERFLOW, 1000 INEXACT.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - data_out = 0, status_out = 0000, out_valid = 0.
  - Internal magnitude, sign and shift count clear.
  - in_ready = 1 in the first cycle after reset is released.
- States: IDLE -> MAGNITUDE -> NORMALIZE -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, capture int_in and go to MAGNITUDE.
- MAGNITUDE (1 cycle):
  - sign = int_in[31].
  - mag = 32-bit unsigned absolute value; 0x80000000 gives mag = 0x80000000.
  - shift count s = 0.
  - If mag == 0: data_out = 0x00000000, status_out = EXACT, go to DONE.
  - Otherwise go to NORMALIZE.
- NORMALIZE:
  - If mag[31] == 0: mag <<= 1, s += 1, stay.
  - Otherwise go to ROUND.
  - Takes s+1 cycles; s is 0..31.
- ROUND (1 cycle):
  - exp = BIAS + 31 - s - FRAC_BITS, computed at 10 bits. It is always in range for legal parameters: minimum 480, maximum 543.
  - man = mag[30:10]; guard = mag[9]; sticky = OR of mag[8:0].
  - Round to nearest, ties to even: round up when guard & (sticky | man[0]).
  - Rounding carry out of man: man = 0, exp += 1.
  - status_out = INEXACT if guard | sticky, otherwise EXACT.
  - data_out = {sign, exp, man}, registered here; go to DONE.
- DONE:
  - out_valid = 1; in_ready = 0; in_valid is ignored.
  - On an edge with out_ready = 1, go to IDLE.
  - data_out and status_out hold until the next result is written. out_valid drops in IDLE.
- Latency: edge count from the accept edge to out_valid high.
  - Zero input: 1 edge.
  - Non-zero input: s+3 edges (3 to 34).
- OVERFLOW and UNDERFLOW are never asserted by this block. The encoding is shared only so the downstream status decode is uniform.
- Handshake edge cases:
  - out_ready held high while DONE is entered: result transfers on the first DONE edge.
  - in_valid asserted in that same cycle: not accepted until IDLE, so there is a minimum 1-cycle bubble.
- Reset mid-operation aborts the conversion. No partial result is emitted.

Decomposition:
- Shared package fpu_pkg contains:
  - the status enum (EXACT/OVERFLOW/UNDERFLOW/INEXACT/idle);
  - EXP_W = 10, MAN_W = 21, BIAS_DEFAULT = 511;
  - field-position constants for sign, exponent and mantissa.
  The FPU adder is migrated to the same package.
- One combinational sub-module, fpu_rne_rounder:
  - inputs: man, guard, sticky, exp;
  - outputs: rounded man, exp, inexact.
  It is reused later by the adder's ARREDONDA stage.

Test Plan:
- int_in = 0x00000001, FRAC_BITS = 0 -> data_out 0x3FE00000, status EXACT, out_valid 34 edges after accept.
- int_in = 0x80000000 -> data_out 0xC3C00000, status EXACT, latency 3.
- int_in = 0x00000003 -> 0x40100000 EXACT. int_in = 0x00000000 -> 0x00000000 EXACT, latency 1.
- Rounding:
  - 0x7FFFFFFF -> 0x43C00000 INEXACT (mantissa carry).
  - 0x00400001 -> 0x42A00000 INEXACT (tie, stays even).
  - 0x00400003 -> 0x42A00002 INEXACT (tie, rounds up).
- Backpressure: out_ready low for 10 cycles in DONE -> data/status/out_valid stable, in_ready 0, pulses on in_valid ignored. Then out_ready = 1 -> IDLE next edge.
- Reset pulse during NORMALIZE of 0x1 -> outputs 0 immediately. After release, a new input 0x3 yields 0x40100000 with the correct latency.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand word layout, exponent/mantissa widths and
// the one-hot status encoding used by the encoder and the adder.
package fpu_pkg;

  localparam int EXP_W        = 10;
  localparam int MAN_W        = 21;
  localparam int BIAS_DEFAULT = 511;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 21;
  localparam int MAN_MSB  = 20;
  localparam int MAN_LSB  = 0;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_EXACT     = 4'b0001,
    ST_OVERFLOW  = 4'b0010,
    ST_UNDERFLOW = 4'b0100,
    ST_INEXACT   = 4'b1000
  } fpu_status_e;

  function automatic logic [31:0] pack_word(input logic sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [MAN_W-1:0] man);
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/fpu_rne_rounder.sv
// Round-to-nearest-even on a hidden-one mantissa; a carry out of the
// mantissa bumps the exponent and leaves the fraction at zero.
module fpu_rne_rounder
  import fpu_pkg::*;
(
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  input  logic             sticky,
  input  logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] man_rounded,
  output logic [EXP_W-1:0] exp_rounded,
  output logic             inexact
);

  logic           round_up;
  logic [MAN_W:0] sum;

  assign round_up = guard & (sticky | man[0]);
  assign inexact  = guard | sticky;

  // Increment the mantissa and resolve the carry into the exponent
  always_comb begin
    sum         = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
    man_rounded = sum[MAN_W-1:0];
    exp_rounded = exp;
    if (sum[MAN_W]) begin
      man_rounded = {MAN_W{1'b0}};
      exp_rounded = exp + {{(EXP_W-1){1'b0}}, 1'b1};
    end else begin
      man_rounded = sum[MAN_W-1:0];
      exp_rounded = exp;
    end
  end

endmodule

// File: rtl/int_to_fpu_encoder.sv
// Signed fixed-point to FPU operand word converter with an iterative
// one-bit-per-cycle normaliser and valid/ready handshakes on both sides.
module int_to_fpu_encoder
  import fpu_pkg::*;
#(
  parameter int FRAC_BITS = 0,
  parameter int BIAS      = BIAS_DEFAULT
) (
  input  logic        clock_100KHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAG   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Exponent when the leading one already sits at bit 31
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31 - FRAC_BITS);

  logic [2:0]       state;
  logic [31:0]      in_latch;
  logic             sign;
  logic [31:0]      mag;
  logic [4:0]       shift;
  logic [EXP_W-1:0] exp_pre;
  logic [MAN_W-1:0] man_rnd;
  logic [EXP_W-1:0] exp_rnd;
  logic             inexact;

  assign exp_pre = EXP_TOP - {{(EXP_W-5){1'b0}}, shift};

  fpu_rne_rounder u_rounder (
    .man         (mag[30:10]),
    .guard       (mag[9]),
    .sticky      (|mag[8:0]),
    .exp         (exp_pre),
    .man_rounded (man_rnd),
    .exp_rounded (exp_rnd),
    .inexact     (inexact)
  );

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_latch   <= 32'd0;
      sign       <= 1'b0;
      mag        <= 32'd0;
      shift      <= 5'd0;
      data_out   <= 32'd0;
      status_out <= ST_IDLE;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_latch <= int_in;
            in_ready <= 1'b0;
            state    <= S_MAG;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_MAG: begin
          sign  <= in_latch[31];
          mag   <= in_latch[31] ? (~in_latch + 32'd1) : in_latch;
          shift <= 5'd0;
          if (in_latch == 32'd0) begin
            data_out   <= 32'd0;
            status_out <= ST_EXACT;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (!mag[31]) begin
            mag   <= {mag[30:0], 1'b0};
            shift <= shift + 5'd1;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          data_out   <= pack_word(sign, exp_rnd, man_rnd);
          status_out <= inexact ? ST_INEXACT : ST_EXACT;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fpu_encoder.sv
// Directed-vector bench for int_to_fpu_encoder with FRAC_BITS = 0, BIAS = 511.
module tb_int_to_fpu_encoder;

  logic        clock_100KHz = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int checks = 0;
  int errors = 0;

  int_to_fpu_encoder dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .int_in       (int_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .status_out   (status_out)
  );

  always #5 clock_100KHz = ~clock_100KHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  // Present one value, measure latency to out_valid and check the result.
  // When release is set, the result is drained with out_ready = 1.
  task automatic run_vec(input string tag, input logic [31:0] v, input logic [31:0] exp_data,
                         input logic [3:0] exp_st, input int exp_lat, input bit release_res);
    int lat;
    @(negedge clock_100KHz);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    int_in   = v;
    @(posedge clock_100KHz);
    #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clock_100KHz);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_status"}, {28'd0, status_out}, {28'd0, exp_st});
    if (release_res) begin
      @(posedge clock_100KHz);
      #1;
      check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    int_in    = 32'd0;
    out_ready = 1'b1;
    #12;
    check("rst_data", data_out, 32'd0);
    check("rst_status", {28'd0, status_out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock_100KHz);
    reset = 1'b0;
    @(posedge clock_100KHz);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_vec("one",      32'h0000_0001, 32'h3FE0_0000, 4'b0001, 34, 1'b1);
    run_vec("minint",   32'h8000_0000, 32'hC3C0_0000, 4'b0001,  3, 1'b1);
    run_vec("three",    32'h0000_0003, 32'h4010_0000, 4'b0001, 33, 1'b1);
    run_vec("zero",     32'h0000_0000, 32'h0000_0000, 4'b0001,  1, 1'b1);
    run_vec("maxint",   32'h7FFF_FFFF, 32'h43C0_0000, 4'b1000,  4, 1'b1);
    run_vec("tie_even", 32'h0040_0001, 32'h42A0_0000, 4'b1000, 12, 1'b1);
    run_vec("tie_up",   32'h0040_0003, 32'h42A0_0002, 4'b1000, 12, 1'b1);
    run_vec("neg_three",32'hFFFF_FFFD, 32'hC010_0000, 4'b0001, 33, 1'b1);

    // Backpressure: result must hold and input pulses must be ignored
    out_ready = 1'b0;
    run_vec("bp", 32'h0000_0003, 32'h4010_0000, 4'b0001, 33, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_100KHz);
      in_valid = i[0];
      int_in   = 32'h0000_0001;
      @(posedge clock_100KHz);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", data_out, 32'h4010_0000);
      check("bp_status", {28'd0, status_out}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock_100KHz);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock_100KHz);
    #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_hold_data", data_out, 32'h4010_0000);

    // Reset while normalising 0x1
    @(negedge clock_100KHz);
    in_valid = 1'b1;
    int_in   = 32'h0000_0001;
    @(posedge clock_100KHz);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clock_100KHz);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_data", data_out, 32'd0);
    check("mid_rst_status", {28'd0, status_out}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock_100KHz);
    reset = 1'b0;
    run_vec("after_rst", 32'h0000_0003, 32'h4010_0000, 4'b0001, 33, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
